// File: rtl/hamming74_serial_rx.sv
// hamming74_serial_rx: serial Hamming(7,4) receiver with single-bit correction and a one-entry output register
module hamming74_serial_rx #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin_valid,
  input  logic       sin_bit,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic [2:0] out_syndrome,
  output logic       out_corrected,
  output logic       overrun,
  output logic       frame_abort
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [CW-1:0] tcnt, tcnt_nxt;
  logic [5:0]    sr;
  logic          done, abort;
  logic [6:0]    code, fixed;
  logic [2:0]    syn;
  logic [3:0]    data;

  // Frame sequencing: bit counting, idle timeout and completion detection
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    done      = 1'b0;
    abort     = 1'b0;
    if (state == IDLE) begin
      if (sin_valid) begin
        state_nxt = RECV;
        cnt_nxt   = 3'd1;
        tcnt_nxt  = '0;
      end
    end else if (sin_valid) begin
      tcnt_nxt = '0;
      if (cnt == 3'd6) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        done      = 1'b1;
      end else begin
        cnt_nxt = cnt + 3'd1;
      end
    end else if (tcnt == CW'(TIMEOUT - 1)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      tcnt_nxt  = '0;
      abort     = 1'b1;
    end else begin
      tcnt_nxt = tcnt + CW'(1);
    end
  end

  // Decode uses the six stored bits plus the bit arriving this cycle; code[k] is position k+1
  assign code  = {sin_bit, sr};
  assign syn   = {code[3] ^ code[4] ^ code[5] ^ code[6],
                  code[1] ^ code[2] ^ code[5] ^ code[6],
                  code[0] ^ code[2] ^ code[4] ^ code[6]};
  assign fixed = (syn == 3'd0) ? code : code ^ (7'd1 << (syn - 3'd1));
  assign data  = {fixed[2], fixed[4], fixed[5], fixed[6]};

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  // Shift register: after six accepted bits sr[0] holds position 1 and sr[5] position 6
  always_ff @(posedge clk) begin
    if (!rst_n) sr <= '0;
    else if (sin_valid) sr <= {sin_bit, sr[5:1]};
  end

  // Output holding register with valid/ready handshake, overrun and abort pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
      overrun       <= 1'b0;
      frame_abort   <= 1'b0;
    end else begin
      overrun     <= 1'b0;
      frame_abort <= abort;
      if (done) begin
        if (!out_valid || out_ready) begin
          out_valid     <= 1'b1;
          out_data      <= data;
          out_syndrome  <= syn;
          out_corrected <= syn != 3'd0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hamming74_serial_rx.sv
// tb_hamming74_serial_rx: table-driven, directed and randomized checks of the Hamming(7,4) serial receiver
module tb_hamming74_serial_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_bit = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_corrected;
  logic       overrun;
  logic       frame_abort;

  int passed = 0;
  int total = 0;
  int aborts = 0;
  int ovr_seen = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [3:0] d;
    int         err;
    logic [3:0] ed;
    logic [2:0] es;
    logic       ec;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic [2:0] s;
    logic       c;
  } exp_t;

  vec_t vecs[9];
  exp_t expq[$];

  hamming74_serial_rx #(.TIMEOUT(15), .CW(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sin_valid(sin_valid),
    .sin_bit(sin_bit),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_syndrome(out_syndrome),
    .out_corrected(out_corrected),
    .overrun(overrun),
    .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else passed++;
  endtask

  // Codeword indexed by position 1..7: data on 3,5,6,7, even parity on 1,2,4
  function automatic logic [7:1] enc(input logic [3:0] d);
    logic [7:1] c;
    c[3] = d[3];
    c[5] = d[2];
    c[6] = d[1];
    c[7] = d[0];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

  function automatic logic [7:1] flip(input logic [7:1] c, input int pos);
    logic [7:1] r;
    r = c;
    if (pos != 0) r[pos] = ~r[pos];
    return r;
  endfunction

  // Sends the first nbits positions; after bit gap_at inserts gap_len idle cycles
  task automatic send_frame(input logic [7:1] cw, input int nbits, input int gap_at,
                            input int gap_len, input bit rnd, input bit rdy7);
    for (int i = 1; i <= nbits; i++) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      if (i == 7 && (rnd || rdy7)) out_ready = 1'b1;
      sin_valid = 1'b1;
      sin_bit   = cw[i];
      @(posedge clk);
      #1;
      sin_valid = 1'b0;
      aborts += int'(frame_abort);
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          if (rnd) out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
          aborts += int'(frame_abort);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      aborts += int'(frame_abort);
    end
  endtask

  // Scoreboard: a transfer happens at the next rising edge when valid and ready are both high
  always @(negedge clk) begin
    if (mon_en) begin
      if (overrun) ovr_seen++;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("rnd_unexpected_word", 32'd1, 32'd0);
        end else begin
          exp_t x;
          x = expq.pop_front();
          chk("rnd_data", 32'(out_data), 32'(x.d));
          chk("rnd_syndrome", 32'(out_syndrome), 32'(x.s));
          chk("rnd_corrected", 32'(out_corrected), 32'(x.c));
        end
      end
    end
  end

  initial begin
    vecs[0] = '{4'b1011, 0, 4'b1011, 3'd0, 1'b0};
    vecs[1] = '{4'b1011, 5, 4'b1011, 3'd5, 1'b1};
    vecs[2] = '{4'b0000, 0, 4'b0000, 3'd0, 1'b0};
    vecs[3] = '{4'b1111, 7, 4'b1111, 3'd7, 1'b1};
    vecs[4] = '{4'b0101, 1, 4'b0101, 3'd1, 1'b1};
    vecs[5] = '{4'b1000, 3, 4'b1000, 3'd3, 1'b1};
    vecs[6] = '{4'b0010, 2, 4'b0010, 3'd2, 1'b1};
    vecs[7] = '{4'b0001, 4, 4'b0001, 3'd4, 1'b1};
    vecs[8] = '{4'b0110, 6, 4'b0110, 3'd6, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_syndrome", 32'(out_syndrome), 32'd0);
    chk("rst_corrected", 32'(out_corrected), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_abort", 32'(frame_abort), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      send_frame(flip(enc(vecs[v].d), vecs[v].err), 7, 0, 0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_valid", v), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_data", v), 32'(out_data), 32'(vecs[v].ed));
      chk($sformatf("tbl%0d_syndrome", v), 32'(out_syndrome), 32'(vecs[v].es));
      chk($sformatf("tbl%0d_corrected", v), 32'(out_corrected), 32'(vecs[v].ec));
      out_ready = 1'b1;
      idle(1);
      chk($sformatf("tbl%0d_drained", v), 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end

    aborts = 0;
    send_frame(enc(4'b1011), 7, 3, 14, 1'b0, 1'b0);
    chk("gap14_valid", 32'(out_valid), 32'd1);
    chk("gap14_data", 32'(out_data), 32'hb);
    chk("gap14_no_abort", 32'(aborts), 32'd0);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;

    aborts = 0;
    send_frame(enc(4'b1011), 4, 4, 15, 1'b0, 1'b0);
    chk("timeout_abort_now", 32'(frame_abort), 32'd1);
    idle(3);
    chk("timeout_abort_once", 32'(aborts), 32'd1);
    chk("timeout_no_valid", 32'(out_valid), 32'd0);
    send_frame(enc(4'b0110), 7, 0, 0, 1'b0, 1'b0);
    chk("after_timeout_valid", 32'(out_valid), 32'd1);
    chk("after_timeout_data", 32'(out_data), 32'h6);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;

    send_frame(enc(4'b1011), 7, 0, 0, 1'b0, 1'b0);
    chk("b2b_first_valid", 32'(out_valid), 32'd1);
    chk("b2b_first_data", 32'(out_data), 32'hb);
    chk("b2b_no_early_overrun", 32'(overrun), 32'd0);
    send_frame(enc(4'b0101), 7, 0, 0, 1'b0, 1'b0);
    chk("b2b_overrun", 32'(overrun), 32'd1);
    chk("b2b_held_data", 32'(out_data), 32'hb);
    chk("b2b_held_valid", 32'(out_valid), 32'd1);
    idle(1);
    chk("b2b_overrun_pulse", 32'(overrun), 32'd0);
    chk("b2b_stable_data", 32'(out_data), 32'hb);
    out_ready = 1'b1;
    idle(1);
    chk("b2b_transfer", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    aborts = 0;
    send_frame(enc(4'b1011), 5, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(20);
    chk("midrst_no_abort", 32'(aborts), 32'd0);
    chk("midrst_no_valid", 32'(out_valid), 32'd0);
    send_frame(enc(4'b1011), 7, 0, 0, 1'b0, 1'b0);
    chk("midrst_valid", 32'(out_valid), 32'd1);
    chk("midrst_data", 32'(out_data), 32'hb);
    send_frame(enc(4'b0101), 7, 0, 0, 1'b0, 1'b1);
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_data", 32'(out_data), 32'h5);
    chk("release_no_overrun", 32'(overrun), 32'd0);
    idle(1);
    chk("release_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    aborts = 0;
    ovr_seen = 0;
    mon_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      logic [3:0] d;
      int e;
      exp_t x;
      d = 4'($urandom_range(0, 15));
      e = $urandom_range(0, 7);
      x.d = d;
      x.s = 3'(e);
      x.c = (e != 0);
      expq.push_back(x);
      send_frame(flip(enc(d), e), 7, $urandom_range(1, 6), $urandom_range(0, 14), 1'b1, 1'b0);
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        out_ready = ($urandom_range(0, 3) != 0);
        idle(1);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && expq.size() != 0; k++) idle(1);
    chk("rnd_drain", 32'(expq.size()), 32'd0);
    chk("rnd_no_abort", 32'(aborts), 32'd0);
    chk("rnd_no_overrun", 32'(ovr_seen), 32'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
